// File: rtl/alu_seq_pkg.sv
// Shared types and flag bit positions for the alu_seq block.
// Optional multi-cycle multiply is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SBC = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, M cycles.
// Compiled and instantiated only when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul #(
    parameter int M = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [M-1:0]     a_i,
    input  logic [M-1:0]     b_i,
    output logic             done_o,
    output logic [2*M-1:0]   product_o
);

    localparam int CW = $clog2(M) + 1;

    logic [2*M-1:0] mcand_q, mcand_d;
    logic [2*M-1:0] acc_q,   acc_d;
    logic [M-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic           busy_q,  busy_d;
    logic [2*M-1:0] acc_sum;

    // Product is exposed combinationally so the last partial sum lands in the same edge as completion.
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CW'(M - 1));
    assign product_o = acc_sum;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i && !busy_q) begin
            mcand_d  = {{M{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked 8-op ALU with persistent {N,Z,C,V,P} flags for carry chaining.
// Define ALU_SEQ_MUL_EN to make opcode 111 an M-cycle multiply; otherwise it passes A through.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int M = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  A,
    input  logic [M-1:0]  B,
    input  logic [2:0]    OpCode,
    output logic          out_valid,
    output logic [M-1:0]  Result,
    output logic [4:0]    Flags
);

    logic [M-1:0] result_q, result_d;
    logic [4:0]   flags_q,  flags_d;
    logic         out_valid_q, out_valid_d;
    logic [M:0]   arith;
    logic         v_bit;
    logic         cq;
    logic         accept;
    op_e          op;

    function automatic logic [4:0] mk_flags(input logic [M-1:0] r, input logic c, input logic v);
        logic [4:0] f;
        f         = '0;
        f[FLAG_N] = r[M-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_P] = ^r;
        return f;
    endfunction

    assign op        = op_e'(OpCode);
    assign cq        = flags_q[FLAG_C];
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Flags     = flags_q;

    always_comb begin
        arith = '0;
        v_bit = 1'b0;
        unique case (op)
            OP_SUB: arith = {1'b0, A} - {1'b0, B};
            OP_ADD: arith = {1'b0, A} + {1'b0, B};
            OP_OR:  arith = {1'b0, A | B};
            OP_AND: arith = {1'b0, A & B};
            OP_XOR: arith = {1'b0, A ^ B};
            OP_ADC: arith = {1'b0, A} + {1'b0, B} + {{M{1'b0}}, cq};
            OP_SBC: arith = {1'b0, A} - {1'b0, B} - {{M{1'b0}}, cq};
            default: arith = {1'b0, A};
        endcase
        if (op == OP_ADD || op == OP_ADC) begin
            v_bit = (~A[M-1] & ~B[M-1] & arith[M-1]) | (A[M-1] & B[M-1] & ~arith[M-1]);
        end else if (op == OP_SUB || op == OP_SBC) begin
            v_bit = (~A[M-1] & B[M-1] & arith[M-1]) | (A[M-1] & ~B[M-1] & ~arith[M-1]);
        end
    end

`ifdef ALU_SEQ_MUL_EN
    state_e           state_q, state_d;
    logic             mul_start;
    logic             mul_done;
    logic [2*M-1:0]   mul_product;

    assign in_ready = (state_q == IDLE);

    alu_seq_mul #(.M(M)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        mul_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && op == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = BUSY;
                end else if (accept) begin
                    result_d    = arith[M-1:0];
                    flags_d     = mk_flags(arith[M-1:0], arith[M], v_bit);
                    out_valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    result_d    = mul_product[M-1:0];
                    flags_d     = mk_flags(mul_product[M-1:0], |mul_product[2*M-1:M], 1'b0);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign in_ready = 1'b1;

    // Opcode 111 falls through the ALU default arm: pass A, C=V=0.
    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        if (accept) begin
            result_d    = arith[M-1:0];
            flags_d     = mk_flags(arith[M-1:0], arith[M], v_bit);
            out_valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
